// File: rtl/da_shift_accum_pkg.sv
// da_shift_accum_pkg: shared widths, FSM state, plane sideband and output rounding/saturation
//   NBLK/Q_W/B_W fix the SRAM geometry; S_W is the width of one summed plane,
//   ACC_W the width of the shift-accumulator.
package da_shift_accum_pkg;
    localparam int NBLK  = 8;
    localparam int Q_W   = 20;
    localparam int B_W   = 16;
    localparam int S_W   = Q_W + 3;
    localparam int ACC_W = S_W + B_W - 1;
    localparam int BC_W  = $clog2(B_W);

    typedef enum logic {IDLE, ACCUM} da_state_t;

    // Travels alongside a plane through the adder tree.
    // vld: plane accumulates, first: overwrite acc, fin: produce y_out,
    // err: pulse frame_err when this slot reaches T3, b: plane weight.
    typedef struct packed {
        logic            vld;
        logic            first;
        logic            fin;
        logic            err;
        logic [BC_W-1:0] b;
    } side_t;

    // Round half up by dropping sh LSBs, then clamp to a signed ow-bit range.
    function automatic logic signed [ACC_W:0] sat_round(input logic signed [ACC_W-1:0] a,
                                                        input int sh, input int ow);
        logic signed [ACC_W:0] h, r, mx;
        h  = sh > 0 ? (ACC_W+1)'(64'sd1 <<< (sh - 1)) : '0;
        r  = ((ACC_W+1)'(a) + h) >>> sh;
        mx = (ACC_W+1)'((64'sd1 <<< (ow - 1)) - 64'sd1);
        return r > mx ? mx : r < ~mx ? ~mx : r;
    endfunction
endpackage

// File: rtl/da_shift_accum_if.sv
// da_shift_accum_if: plane input bus and filter output bus of the DA shift-accumulator
//   master drives q/q_valid/q_first/q_last and observes y_out/y_valid/frame_err/busy;
//   slave (the accumulator) is the mirror image.
interface da_shift_accum_if
    import da_shift_accum_pkg::*;
#(
    parameter int OUT_W = 24
);
    logic signed [Q_W-1:0]   q [NBLK];
    logic                    q_valid;
    logic                    q_first;
    logic                    q_last;
    logic signed [OUT_W-1:0] y_out;
    logic                    y_valid;
    logic                    frame_err;
    logic                    busy;

    modport master (output q, q_valid, q_first, q_last, input y_out, y_valid, frame_err, busy);
    modport slave  (input q, q_valid, q_first, q_last, output y_out, y_valid, frame_err, busy);
endinterface

// File: rtl/da_shift_accum_adder_tree8.sv
// da_adder_tree8: two-stage pipelined sum of 8 signed partial sums with delayed sideband
//   clk, rst  : clock, synchronous active-high reset (clears sideband only)
//   q_i       : 8 signed Q_W-bit partial sums of the current plane
//   side_i    : plane sideband entering T1
//   s_o       : the two T2 partial sums (Q_W+2 bits each)
//   side_o    : sideband aligned with s_o
//   busy_o    : a valid plane sits in T1 or T2
module da_adder_tree8
    import da_shift_accum_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic signed [Q_W-1:0] q_i [NBLK],
    input  side_t                 side_i,
    output logic signed [Q_W+1:0] s_o [2],
    output side_t                 side_o,
    output logic                  busy_o
);
    logic signed [Q_W:0]   p_q [4];
    logic signed [Q_W+1:0] s_q [2];
    side_t                 side1_q, side2_q;

    always_ff @(posedge clk) begin
        p_q[0] <= (Q_W+1)'(q_i[0]) + (Q_W+1)'(q_i[1]);
        p_q[1] <= (Q_W+1)'(q_i[2]) + (Q_W+1)'(q_i[3]);
        p_q[2] <= (Q_W+1)'(q_i[4]) + (Q_W+1)'(q_i[5]);
        p_q[3] <= (Q_W+1)'(q_i[6]) + (Q_W+1)'(q_i[7]);
        s_q[0] <= (Q_W+2)'(p_q[0]) + (Q_W+2)'(p_q[1]);
        s_q[1] <= (Q_W+2)'(p_q[2]) + (Q_W+2)'(p_q[3]);
        if (rst) begin
            side1_q <= '0;
            side2_q <= '0;
        end else begin
            side1_q <= side_i;
            side2_q <= side1_q;
        end
    end

    assign s_o    = s_q;
    assign side_o = side2_q;
    assign busy_o = side1_q.vld | side2_q.vld;
endmodule

// File: rtl/da_shift_accum.sv
// da_shift_accum: DA FIR back end; sums 8 SRAM partial sums per bit-plane and
//   shift-accumulates B_W planes (MSB plane negative) into one rounded, saturated output.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of da_shift_accum_if (planes in, y_out/y_valid/frame_err/busy out)
//   OUT_W    : output width; OUT_SHIFT: LSBs dropped with round-half-up before saturation
module da_shift_accum
    import da_shift_accum_pkg::*;
#(
    parameter int OUT_W     = 24,
    parameter int OUT_SHIFT = 14
) (
    input logic             clk,
    input logic             rst,
    da_shift_accum_if.slave bus
);
    localparam logic [BC_W-1:0] B_LAST = BC_W'(B_W - 1);

    da_state_t               state_q, state_d;
    logic [BC_W-1:0]         b_q, b_d, b_inc;
    side_t                   side_d, t2_side;
    logic signed [Q_W+1:0]   t2_s [2];
    logic                    tree_busy;
    logic signed [S_W-1:0]   s_sum;
    logic signed [ACC_W-1:0] term, acc_q, acc_d, acc_f;
    logic signed [OUT_W-1:0] y_q;
    logic                    yv_q, err_q;

    assign b_inc = b_q + 1'b1;

    // Frame protocol is resolved at the input; its verdict rides the sideband to T3.
    always_comb begin
        state_d = state_q;
        b_d     = b_q;
        side_d  = '0;
        if (bus.q_valid) begin
            if (bus.q_first && bus.q_last) begin
                state_d    = IDLE;
                side_d.err = 1'b1;
            end else if (bus.q_first) begin
                // a first plane inside an open frame restarts it and flags the lost frame
                state_d      = ACCUM;
                b_d          = '0;
                side_d.vld   = 1'b1;
                side_d.first = 1'b1;
                side_d.err   = state_q == ACCUM;
            end else if (state_q == IDLE) begin
                side_d.err = 1'b1;
            end else if (b_inc == B_LAST) begin
                state_d    = IDLE;
                side_d.vld = bus.q_last;
                side_d.fin = bus.q_last;
                side_d.err = !bus.q_last;
                side_d.b   = B_LAST;
            end else if (bus.q_last) begin
                state_d    = IDLE;
                side_d.err = 1'b1;
            end else begin
                b_d        = b_inc;
                side_d.vld = 1'b1;
                side_d.b   = b_inc;
            end
        end
    end

    da_adder_tree8 u_tree (
        .clk    (clk),
        .rst    (rst),
        .q_i    (bus.q),
        .side_i (side_d),
        .s_o    (t2_s),
        .side_o (t2_side),
        .busy_o (tree_busy)
    );

    // T3: final tree add, weight by plane index; MSB plane carries negative weight.
    assign s_sum = S_W'(t2_s[0]) + S_W'(t2_s[1]);
    assign term  = ACC_W'(s_sum) <<< t2_side.b;
    assign acc_f = acc_q - term;
    assign acc_d = !t2_side.vld ? acc_q : t2_side.first ? term : t2_side.fin ? acc_f : acc_q + term;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            b_q     <= '0;
            acc_q   <= '0;
            y_q     <= '0;
            yv_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            yv_q    <= t2_side.vld && t2_side.fin;
            err_q   <= t2_side.err;
            if (t2_side.vld && t2_side.fin)
                y_q <= OUT_W'(sat_round(acc_f, OUT_SHIFT, OUT_W));
        end
    end

    assign bus.y_out     = y_q;
    assign bus.y_valid   = yv_q;
    assign bus.frame_err = err_q;
    assign bus.busy      = state_q == ACCUM || tree_busy;
endmodule
